div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for RV32M divide ops (DIV, DIVU, REM, REMU).
- Time-shares one 32-bit subtractor stage over 32 restoring-division iterations.
- Sits beside the ALU in the execute stage; the core stalls while busy is high and consumes the result on the valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; only 32 supported (subtractor stage is fixed 32-bit).
- CNT_W, 6, iteration counter width (holds 0..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse/level; accepted only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  input  32  dividend (rs1)
- b  input  32  divisor (rs2)
- busy  output  1  high from the cycle after acceptance until the result is consumed
- valid  output  1  result available
- ready  input  1  consumer accepts result when valid & ready
- result  output  32  quotient or remainder per op

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, valid=0, result=0; counter, Q and R cleared.
  - Applies in any state and aborts an in-flight operation with no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch op, compute signed flags, and load magnitudes |a|, |b| (signed ops only; unsigned ops pass through). Q=|a|, R=0, counter=0.
  - If b==0: result = (op is DIV/DIVU) ? 32'hFFFF_FFFF : a; go to DONE.
  - Else if op==DIV/REM, a==32'h8000_0000 and b==32'hFFFF_FFFF: result = DIV ? 32'h8000_0000 : 0; go to DONE.
  - Otherwise go to CALC.
- CALC, one iteration per cycle:
  - {msb,Rs} = {R, Q[31]} shifted left by 1.
  - Subtract: d = Rs - |b|; co = 1 means no borrow.
  - If msb | co: R = d, Q = {Q[30:0],1}. Else: R = Rs, Q = {Q[30:0],0}.
  - counter += 1; after the 32nd iteration go to FIX.
- FIX (1 cycle):
  - Quotient negated if signed op and sign(a) != sign(b).
  - Remainder negated if signed op and a negative (remainder takes the dividend's sign).
  - Register the selected value into result; go to DONE.
- DONE:
  - valid=1; result held stable.
  - On ready=1: valid drops the next cycle and the block returns to IDLE.
  - start is ignored while valid=1.
- Latency from start acceptance to valid:
  - normal ops: 34 cycles (32 CALC + 1 FIX + 1 into DONE).
  - divide-by-zero and overflow: 1 cycle.
- busy=1 in CALC, FIX and DONE; busy=0 in IDLE.
- Back-to-back: start may be asserted in the same cycle as the handshake, but is accepted only once the block is in IDLE (one cycle later).
- Operands are sampled only at acceptance; a/b/op changes during CALC have no effect.
- Subtractor is purely combinational; no other arithmetic unit is instantiated except the two's-complement negators at load and at FIX.

Decomposition:
- Shared package (alu_pkg):
  - div_op_e enum (DIV, DIVU, REM, REMU)
  - div_state_e enum (IDLE, CALC, FIX, DONE)
  - XLEN constant
  - constants DIV0_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000
- Sub-module: one instance of the existing 32-bit subtractor stage (a - b, c_out = no-borrow) for the trial subtraction.
- Negation stays inline; counter and FSM stay in div_seq_ctrl.

Test Plan:
- DIVU a=100, b=7, ready=1 -> valid after 34 cycles, result=14; repeat with REMU -> result=2.
- DIV a=-7 (32'hFFFF_FFF9), b=2 -> result=32'hFFFF_FFFD (-3); REM same operands -> 32'hFFFF_FFFF (-1).
- DIVU a=5, b=0 -> valid after 1 cycle, result=32'hFFFF_FFFF; REMU a=5, b=0 -> result=5.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> result=32'h8000_0000 in 1 cycle; REM same operands -> result=0.
- DIVU a=32'hFFFF_FFFF, b=32'h8000_0001 with ready held 0 for 5 cycles -> result=1 held stable with valid=1 throughout; start pulses during that window are ignored; after ready=1, valid=0 and busy=0 next cycle.
- Assert rst at CALC iteration 10 of DIVU 1000/3 -> next cycle busy=0, valid=0, result=0; a new DIVU 1000/3 then returns 333.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage arithmetic blocks.
package alu_pkg;

  localparam int XLEN = 32;

  // Architectural results for the two RV32M divide corner cases.
  localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  // Encoding matches the two op bits delivered by the decoder.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_sub.sv
// 32-bit subtractor stage: o_diff = i_a - i_b, o_c_out = 1 when no borrow.
module div_seq_ctrl_sub
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_diff,
  output logic            o_c_out
);

  logic w_borrow;

  // Zero-extend by one bit so the top bit of the difference is the borrow.
  assign {w_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};
  assign o_c_out            = ~w_borrow;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for RV32M DIV/DIVU/REM/REMU: 32 restoring iterations on one
// shared subtractor, sign fix-up, then a valid/ready result handshake.
module div_seq_ctrl #(
  parameter int XLEN  = 32,  // only 32 is supported by the subtractor stage
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            valid,
  input  logic            ready,
  output logic [XLEN-1:0] result
);

  import alu_pkg::*;

  div_state_e       r_state, w_state_nxt;
  div_op_e          r_op, w_op_nxt;
  logic             r_neg_q, w_neg_q_nxt;
  logic             r_neg_r, w_neg_r_nxt;
  logic [XLEN-1:0]  r_q, w_q_nxt;
  logic [XLEN-1:0]  r_r, w_r_nxt;
  logic [XLEN-1:0]  r_bmag, w_bmag_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]  r_result, w_result_nxt;

  div_op_e          w_op_in;
  logic             w_in_signed;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_msb;
  logic [XLEN-1:0]  w_rs;
  logic [XLEN-1:0]  w_diff;
  logic             w_co;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_rem;

  // Operand conditioning at acceptance: signed ops work on magnitudes.
  assign w_op_in     = div_op_e'(op);
  assign w_in_signed = (w_op_in == DIV) || (w_op_in == REM);
  assign w_a_mag     = (w_in_signed && a[XLEN-1]) ? -a : a;
  assign w_b_mag     = (w_in_signed && b[XLEN-1]) ? -b : b;

  // Partial remainder shifted left with the next dividend bit; the bit
  // shifted out of R means the trial subtraction always succeeds.
  assign w_msb     = r_r[XLEN-1];
  assign w_rs      = {r_r[XLEN-2:0], r_q[XLEN-1]};
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_rem     = r_op inside {REM, REMU};

  div_seq_ctrl_sub u_sub (
    .i_a     (w_rs),
    .i_b     (r_bmag),
    .o_diff  (w_diff),
    .o_c_out (w_co)
  );

  // Next-state and datapath update for every state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_q_nxt      = r_q;
    w_r_nxt      = r_r;
    w_bmag_nxt   = r_bmag;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_op_nxt    = w_op_in;
          w_neg_q_nxt = w_in_signed && (a[XLEN-1] ^ b[XLEN-1]);
          w_neg_r_nxt = w_in_signed && a[XLEN-1];
          w_q_nxt     = w_a_mag;
          w_r_nxt     = '0;
          w_bmag_nxt  = w_b_mag;
          w_cnt_nxt   = '0;
          if (b == '0) begin
            w_result_nxt = op[1] ? a : DIV0_Q;
            w_state_nxt  = DONE;
          end else if (w_in_signed && (a == INT_MIN) && (b == '1)) begin
            w_result_nxt = op[1] ? '0 : INT_MIN;
            w_state_nxt  = DONE;
          end else begin
            w_state_nxt = CALC;
          end
        end
      end

      CALC: begin
        if (w_msb || w_co) begin
          w_r_nxt = w_diff;
          w_q_nxt = {r_q[XLEN-2:0], 1'b1};
        end else begin
          w_r_nxt = w_rs;
          w_q_nxt = {r_q[XLEN-2:0], 1'b0};
        end
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == CNT_W'(XLEN)) begin
          w_state_nxt = FIX;
        end
      end

      FIX: begin
        if (w_rem) begin
          w_result_nxt = r_neg_r ? -r_r : r_r;
        end else begin
          w_result_nxt = r_neg_q ? -r_q : r_q;
        end
        w_state_nxt = DONE;
      end

      DONE: begin
        if (ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the
    // pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: operands, flags, Q/R, counter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= DIV;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_bmag   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_op     <= w_op_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_q      <= w_q_nxt;
      r_r      <= w_r_nxt;
      r_bmag   <= w_bmag_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy   = (r_state != IDLE);
  assign valid  = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed RV32M divide vectors with
// literal expectations plus a cycle-level reference model of the handshake.
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  div_seq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .valid  (valid),
    .ready  (ready),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M divide result.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(x) / $signed(y);
      2'b01:   return x / y;
      2'b10:   return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  // Edges from acceptance (inclusive) until valid is seen.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Reference model: idle/busy/valid countdown with the arithmetic result.
  logic        m_init = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_exp = 32'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    m_init <= 1'b1;
    if (rst) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= 32'd0;
      m_left   <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_exp  <= ref_res(op, a, b);
        if (ref_lat(op, a, b) == 1) begin
          m_valid  <= 1'b1;
          m_result <= ref_res(op, a, b);
        end else begin
          m_left <= ref_lat(op, a, b) - 2;
        end
      end
    end else if (m_valid) begin
      if (ready) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else if (m_left == 0) begin
      m_valid  <= 1'b1;
      m_result <= m_exp;
    end else begin
      m_left <= m_left - 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("model busy", 32'(busy), 32'(m_busy));
      check("model valid", 32'(valid), 32'(m_valid));
      if (m_valid) check("model result", result, m_result);
    end
  end

  // One operation: issue, measure latency, optionally stall, then consume.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_r, input int exp_lat,
                        input int hold, input logic b2b);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; ready = 1'b0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (!valid && n < 100);
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " result"}, result, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = i[0]; a = $urandom; b = $urandom; op = i[1:0];
      @(posedge clk); #1;
      check({name, " held valid"}, 32'(valid), 32'd1);
      check({name, " held result"}, result, exp_r);
    end
    @(negedge clk);
    op = o; a = x; b = y; start = b2b; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    start = 1'b0;
    check({name, " valid after ack"}, 32'(valid), 32'd0);
    check({name, " busy after ack"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    // Unsigned pair, second one issued back-to-back with the first handshake.
    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0, 1'b1);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 0, 1'b0);

    // Signed results truncate toward zero; remainder follows the dividend.
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 1'b0);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 1'b0);
    run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, 1'b0);
    run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0, 1'b0);
    run_op("div -20/-6", 2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'd3, 34, 0, 1'b0);
    run_op("rem -20/-6", 2'b10, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 34, 0, 1'b0);
    run_op("div min/3", 2'b00, 32'h8000_0000, 32'd3, 32'hD555_5556, 34, 0, 1'b0);
    run_op("rem min/3", 2'b10, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 34, 0, 1'b0);
    run_op("div 0/-5", 2'b00, 32'd0, 32'hFFFF_FFFB, 32'd0, 34, 0, 1'b0);

    // Divide by zero and signed overflow finish in one cycle.
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0);
    run_op("div -3/0", 2'b00, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op("rem -3/0", 2'b10, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 1, 0, 1'b0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
    run_op("divu min/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0, 1'b0);

    // Consumer stalls for 5 cycles while start pulses are ignored.
    run_op("divu stall", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 5, 1'b0);

    // Reset during CALC iteration 10 aborts with no output.
    @(negedge clk);
    op = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    check("abort result", result, 32'd0);
    run_op("divu 1000/3", 2'b01, 32'd1000, 32'd3, 32'd333, 34, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
